// File: rtl/conv_window_addr_gen.sv
// ---------------------------------------------------------------------------
// conv_window_addr_gen
//
// Purpose:
//   Produces image-buffer read addresses for a KxK convolution window that
//   slides with stride 1 over an IMG_H x IMG_W feature map. Four nested
//   counters walk the map, outermost first: window row, window column,
//   kernel row, kernel column. One address is consumed per valid/ready
//   handshake. The last tap of every window is flagged, and a one-cycle
//   done pulse follows the final tap of the final window.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   request a full map scan (only honoured in IDLE)
//   abort       in   synchronous abort back to IDLE, no done pulse
//   addr_ready  in   downstream accepts addr this cycle
//   addr_valid  out  addr / win_row / win_col / tap_last are valid
//   addr        out  pixel address (win_row+kr)*IMG_W + (win_col+kc)
//   win_row     out  current window top-left row
//   win_col     out  current window top-left column
//   tap_last    out  current address is the final tap of its window
//   busy        out  high while scanning and during the done cycle
//   done        out  one-cycle pulse after the final handshake
// ---------------------------------------------------------------------------
module conv_window_addr_gen #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]  win_row,
    output logic [CNT_W-1:0]  win_col,
    output logic              tap_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam logic [CNT_W-1:0]  KLast   = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0]  ColLast = CNT_W'(IMG_W - K);
    localparam logic [CNT_W-1:0]  RowLast = CNT_W'(IMG_H - K);
    localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(IMG_W);

    stateT             r_state;
    stateT             w_stateNext;

    logic [CNT_W-1:0]  r_kc;
    logic [CNT_W-1:0]  r_kr;
    logic [CNT_W-1:0]  r_winCol;
    logic [CNT_W-1:0]  r_winRow;

    // r_winBase tracks win_row*IMG_W, r_rowBase tracks (win_row+kr)*IMG_W,
    // both maintained by adding IMG_W so no multiplier is needed.
    logic [ADDR_W-1:0] r_winBase;
    logic [ADDR_W-1:0] r_rowBase;

    logic              w_handshake;
    logic              w_tapLast;
    logic              w_winLast;
    logic              w_scanLast;

    assign w_handshake = (r_state == RUN) && addr_ready;
    assign w_tapLast   = (r_kr == KLast) && (r_kc == KLast);
    assign w_winLast   = (r_winRow == RowLast) && (r_winCol == ColLast);
    assign w_scanLast  = w_handshake && w_tapLast && w_winLast;

    // Address and window position come straight from the counter registers,
    // so they hold steady for as long as the consumer stalls.
    assign addr    = r_rowBase + ADDR_W'(r_winCol) + ADDR_W'(r_kc);
    assign win_row = r_winRow;
    assign win_col = r_winCol;

    // State register. Everything else about control flow is decided in the
    // combinational block below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and output decode. abort overrides every transition,
    // including a simultaneous start in IDLE or the final handshake in RUN,
    // which is why it is applied last. Outputs depend only on the state and
    // registered counters, never on addr_ready.
    always_comb begin
        w_stateNext = r_state;
        addr_valid  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        tap_last    = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                addr_valid = 1'b1;
                busy       = 1'b1;
                tap_last   = w_tapLast;
                if (w_scanLast) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase

        if (abort) begin
            w_stateNext = IDLE;
        end
    end

    // Nested loop counters. They are held at zero outside RUN, cleared on
    // abort and on the final handshake, and otherwise advance only when an
    // address is accepted. Each wrap of an inner counter carries into the
    // next outer one, and the row-base registers step by IMG_W alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kc      <= '0;
            r_kr      <= '0;
            r_winCol  <= '0;
            r_winRow  <= '0;
            r_winBase <= '0;
            r_rowBase <= '0;
        end else if (abort || (r_state != RUN) || w_scanLast) begin
            r_kc      <= '0;
            r_kr      <= '0;
            r_winCol  <= '0;
            r_winRow  <= '0;
            r_winBase <= '0;
            r_rowBase <= '0;
        end else if (w_handshake) begin
            if (r_kc != KLast) begin
                r_kc <= r_kc + 1'b1;
            end else begin
                r_kc <= '0;
                if (r_kr != KLast) begin
                    r_kr      <= r_kr + 1'b1;
                    r_rowBase <= r_rowBase + RowStep;
                end else begin
                    r_kr <= '0;
                    if (r_winCol != ColLast) begin
                        r_winCol  <= r_winCol + 1'b1;
                        r_rowBase <= r_winBase;
                    end else begin
                        r_winCol  <= '0;
                        r_winRow  <= r_winRow + 1'b1;
                        r_winBase <= r_winBase + RowStep;
                        r_rowBase <= r_winBase + RowStep;
                    end
                end
            end
        end
    end

endmodule
